// File: rtl/axis_pair_unpack_checker.sv
// axis_pair_unpack_checker
// Read-end sink for the counter datapath. Re-packs pairs of IN_W-bit beats
// (upper half first) into 2*IN_W-bit words, checks them against an
// incrementing counter sequence and the expected frame length, and reports
// the words, a word count, a saturating error count and a done pulse.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; counts from the last frame are held
// S_HI   | expecting the upper half of the next word
// S_LO   | upper half captured in hi_reg; expecting the lower half
// S_DONE | frame closed; done is high for this single cycle
module axis_pair_unpack_checker #(
   parameter int IN_W  = 3,
   parameter int LEN_W = 6,
   parameter int ERR_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LEN_W-1:0]    cnt_limit,
   input  logic [2*IN_W-1:0]   seed,
   input  logic                hold,
   input  logic                s_axis_tvalid,
   input  logic [IN_W-1:0]     s_axis_tdata,
   input  logic                s_axis_tlast,
   output logic                s_axis_tready,
   output logic                word_valid,
   output logic [2*IN_W-1:0]   word_data,
   output logic [LEN_W-1:0]    word_count,
   output logic [ERR_W-1:0]    err_count,
   output logic                busy,
   output logic                done
);

   localparam int W = 2 * IN_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HI   = 2'd1,
      S_LO   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state;
   logic [IN_W-1:0]   hi_reg;
   logic [W-1:0]      exp_word;
   logic [LEN_W-1:0]  exp_len;

   logic              hs;
   logic [W-1:0]      lo_word;
   logic [LEN_W-1:0]  count_inc;
   logic              lo_last;
   logic              lo_mismatch;
   logic              lo_framing;
   logic [1:0]        lo_err;

   // Adds a small increment to the error counter, pinning at all-ones.
   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] base,
                                                input logic [1:0]       inc);
      logic [ERR_W:0] sum;
      sum = {1'b0, base} + (ERR_W+1)'(inc);
      return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
   endfunction

   // Ready and busy come straight from registered state, so tvalid never
   // reaches tready combinationally.
   assign busy          = (state == S_HI) || (state == S_LO);
   assign s_axis_tready = busy && !hold;
   assign hs            = s_axis_tvalid && s_axis_tready;

   // Lower-half evaluation: the candidate word, whether it closes the frame,
   // and how many errors it contributes. A length/tlast disagreement in
   // either direction is one framing error; a data mismatch adds another.
   assign lo_word     = {hi_reg, s_axis_tdata};
   assign count_inc   = word_count + LEN_W'(1);
   assign lo_last     = (count_inc == exp_len);
   assign lo_mismatch = (lo_word != exp_word);
   assign lo_framing  = lo_last ^ s_axis_tlast;
   assign lo_err      = {1'b0, lo_mismatch} + {1'b0, lo_framing};

   // Frame sequencer with registered strobes, counters and word output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         hi_reg     <= '0;
         exp_word   <= '0;
         exp_len    <= '0;
         word_valid <= 1'b0;
         word_data  <= '0;
         word_count <= '0;
         err_count  <= '0;
         done       <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         done       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  exp_len    <= cnt_limit;
                  exp_word   <= seed;
                  word_count <= '0;
                  err_count  <= '0;
                  if (cnt_limit == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_HI;
                  end
               end
            end
            S_HI: begin
               if (hs) begin
                  hi_reg <= s_axis_tdata;
                  if (s_axis_tlast) begin
                     // tlast on an upper half cannot end a whole word
                     err_count <= sat_add(err_count, 2'd1);
                     state     <= S_DONE;
                     done      <= 1'b1;
                  end else begin
                     state <= S_LO;
                  end
               end
            end
            S_LO: begin
               if (hs) begin
                  word_data  <= lo_word;
                  word_valid <= 1'b1;
                  word_count <= count_inc;
                  exp_word   <= exp_word + W'(1);
                  err_count  <= sat_add(err_count, lo_err);
                  if (lo_last || s_axis_tlast) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_HI;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pair_unpack_checker.sv
// Scoreboard bench for axis_pair_unpack_checker: a frame-level reference
// model predicts words and final counts, a monitor compares DUT output.
module tb_axis_pair_unpack_checker;

   localparam int IN_W  = 3;
   localparam int LEN_W = 6;
   localparam int ERR_W = 8;
   localparam int W     = 2 * IN_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [LEN_W-1:0]  cnt_limit;
   logic [W-1:0]      seed;
   logic              hold;
   logic              s_axis_tvalid;
   logic [IN_W-1:0]   s_axis_tdata;
   logic              s_axis_tlast;
   logic              s_axis_tready;
   logic              word_valid;
   logic [W-1:0]      word_data;
   logic [LEN_W-1:0]  word_count;
   logic [ERR_W-1:0]  err_count;
   logic              busy;
   logic              done;

   axis_pair_unpack_checker #(.IN_W(IN_W), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cnt_limit(cnt_limit),
      .seed(seed), .hold(hold), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready), .word_valid(word_valid),
      .word_data(word_data), .word_count(word_count), .err_count(err_count),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IN_W-1:0] d;
      logic            l;
   } beat_t;

   typedef struct {
      int cnt;
      int err;
      int beats;
   } frame_t;

   int          exp_words[$];
   frame_t      exp_frames[$];
   beat_t       gen[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_hs_cyc = 0;
   int          frame_hs = 0;
   int          done_cnt = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every emitted word and every done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold) check("tready_under_hold", int'(s_axis_tready), 0);
         if (word_valid) begin
            if (exp_words.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_word actual=%0d required=none", word_data);
            end else begin
               check("word_data", int'(word_data), exp_words.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            if (exp_frames.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               frame_t f;
               f = exp_frames.pop_front();
               check("word_count", int'(word_count), f.cnt);
               check("err_count", int'(err_count), f.err);
               check("beats_accepted", frame_hs, f.beats);
               check("busy_at_done", int'(busy), 0);
               if (f.beats > 0) check("done_latency", cyc - last_hs_cyc, 1);
            end
         end
      end
   end

   // Fills gen with a correct frame: n words counting up from s, MSB half first.
   task automatic gen_good(input int s, input int n);
      gen.delete();
      for (int k = 0; k < n; k++) begin
         int v;
         beat_t b;
         v = (s + k) % 64;
         b.d = IN_W'(v / 8); b.l = 1'b0; gen.push_back(b);
         b.d = IN_W'(v % 8); b.l = (k == n - 1); gen.push_back(b);
      end
   endtask

   // Presents beats; gap_mode 0 = always valid, 1 = toggle, 2 = random gaps.
   task automatic drive(input beat_t bq[$], input int gap_mode, input int hold_pct,
                        input int hold_start, input int hold_len);
      int idx = 0;
      int n = 0;
      while (idx < bq.size() && n < 2000) begin
         hold = ((hold_start >= 0) && (n >= hold_start) && (n < hold_start + hold_len))
                || (int'($urandom_range(99)) < hold_pct);
         case (gap_mode)
            1:       s_axis_tvalid = (n % 2 == 0);
            2:       s_axis_tvalid = ($urandom_range(99) >= 30);
            default: s_axis_tvalid = 1'b1;
         endcase
         s_axis_tdata = bq[idx].d;
         s_axis_tlast = bq[idx].l;
         @(negedge clk);
         if (s_axis_tvalid && s_axis_tready) begin
            last_hs_cyc = cyc;
            frame_hs++;
            idx++;
         end
         @(posedge clk); #1;
         n++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      hold          = 1'b0;
      if (idx < bq.size()) begin
         checks++; failures++;
         $display("FAIL beat_timeout actual=%0d required=%0d", idx, bq.size());
      end
   endtask

   // Reference model plus frame execution. Called at posedge+1.
   task automatic run_frame(input int s, input int limit, input beat_t bq_in[$],
                            input int gap_mode, input int hold_pct,
                            input int hold_start, input int hold_len);
      beat_t bq[$];
      int    expv, words, err, i, d0;
      bit    fin;
      logic [W-1:0] w;
      bq = bq_in;
      expv = s; words = 0; err = 0; i = 0; fin = (limit == 0);
      while (!fin && i < bq.size()) begin
         beat_t hi, lo;
         hi = bq[i]; i++;
         if (hi.l) begin err++; fin = 1; break; end
         if (i >= bq.size()) break;
         lo = bq[i]; i++;
         w = {hi.d, lo.d};
         words++;
         exp_words.push_back(int'(w));
         if (int'(w) != expv) err++;
         expv = (expv + 1) % 64;
         if (words == limit || lo.l) begin
            if (!(words == limit && lo.l)) err++;
            fin = 1;
         end
      end
      if (err > 255) err = 255;
      while (bq.size() > i) void'(bq.pop_back());
      if (fin) exp_frames.push_back('{words, err, i});
      d0 = done_cnt;
      frame_hs = 0;
      start = 1'b1; seed = W'(s); cnt_limit = LEN_W'(limit);
      @(posedge clk); #1;
      start = 1'b0;
      if (limit != 0) begin
         check("busy_after_start", int'(busy), 1);
         check("tready_after_start", int'(s_axis_tready), 1);
      end
      drive(bq, gap_mode, hold_pct, hold_start, hold_len);
      if (fin) begin
         int t = 0;
         while (done_cnt == d0 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         if (done_cnt == d0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=0 required=1");
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tready"}, int'(s_axis_tready), 0);
      check({tag, "_word_valid"}, int'(word_valid), 0);
      check({tag, "_word_data"}, int'(word_data), 0);
      check({tag, "_word_count"}, int'(word_count), 0);
      check({tag, "_err_count"}, int'(err_count), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   initial begin
      int d0;
      rst_n = 1'b0; start = 1'b0; cnt_limit = '0; seed = '0; hold = 1'b0;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
      #12;
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Clean back-to-back frame 12..21
      gen_good(12, 10);
      run_frame(12, 10, gen, 0, 0, -1, 0);

      // Same frame with toggling tvalid and a 5-cycle hold mid-word
      gen_good(12, 10);
      run_frame(12, 10, gen, 1, 0, 7, 5);

      // Counter wrap 63 -> 0 -> 1
      gen_good(63, 3);
      run_frame(63, 3, gen, 0, 0, -1, 0);

      // Third word corrupted to 0 and tlast missing on beat 8
      gen_good(5, 4);
      gen[4].d = '0; gen[5].d = '0; gen[7].l = 1'b0;
      run_frame(5, 4, gen, 0, 0, -1, 0);

      // tlast on an upper-half beat
      gen_good(0, 5);
      gen[2].l = 1'b1;
      run_frame(0, 5, gen, 0, 0, -1, 0);
      check("tready_after_framing", int'(s_axis_tready), 0);

      // Zero-length frame
      gen.delete();
      run_frame(9, 0, gen, 0, 0, -1, 0);

      // Reset asserted after beat 5 of a 10-word frame
      gen_good(20, 10);
      while (gen.size() > 5) void'(gen.pop_back());
      run_frame(20, 10, gen, 0, 0, -1, 0);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      check("midreset_words_left", exp_words.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midreset_no_done", done_cnt, d0);
      gen_good(30, 6);
      run_frame(30, 6, gen, 0, 0, -1, 0);

      // Randomised frames with occasional corruption
      for (int f = 0; f < 15; f++) begin
         int s, lim, kind;
         s = $urandom_range(63);
         lim = $urandom_range(15, 1);
         kind = $urandom_range(3);
         gen_good(s, lim);
         if (kind == 1) begin
            int k = $urandom_range(gen.size() - 1);
            gen[k].d = gen[k].d ^ IN_W'($urandom_range(7, 1));
         end else if (kind == 2) begin
            gen[gen.size() - 1].l = 1'b0;
         end else if (kind == 3) begin
            gen[$urandom_range(gen.size() - 1)].l = 1'b1;
         end
         run_frame(s, lim, gen, 2, 20, -1, 0);
         repeat ($urandom_range(2)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      check("leftover_words", exp_words.size(), 0);
      check("leftover_frames", exp_frames.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axis_pair_unpack_checker.md
# axis_pair_unpack_checker

AXI-Stream sink for the counter datapath. It accepts 3-bit beats from the 6-to-3 width-converting data FIFO and re-packs each pair of beats into one 6-bit word, upper half first. It checks every word against the expected incrementing counter sequence and the frame length, and reports packed words, a word count, a saturating error count and a done pulse. It sits at the read end of the FIFO and closes the loop for self-checking counter runs.

## Interface
Parameters:
- IN_W, 3, beat width; the output word is 2*IN_W.
- LEN_W, 6, width of the frame-length input and of the word counter.
- ERR_W, 8, width of the saturating error counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- cnt_limit  in  LEN_W  words expected in the frame; latched on start.
- seed  in  2*IN_W  expected value of the first word; latched on start.
- hold  in  1  forces tready low, for backpressure.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tdata  in  IN_W  beat data.
- s_axis_tlast  in  1  last beat of the frame.
- s_axis_tready  out  1  sink ready.
- word_valid  out  1  one-cycle strobe; word_data is valid.
- word_data  out  2*IN_W  packed word, {first beat, second beat}.
- word_count  out  LEN_W  words accepted in the current or last frame.
- err_count  out  ERR_W  errors in the current or last frame; saturates at all-ones.
- busy  out  1  high in the HI and LO states.
- done  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, HI, LO, DONE.
- IDLE, start=1:
  - latch cnt_limit and seed into exp_len and exp_word;
  - clear word_count and err_count;
  - go to HI, or to DONE if cnt_limit=0.
- A beat handshake is s_axis_tvalid & s_axis_tready.
- s_axis_tready = (state==HI | state==LO) & ~hold. It is decoded from registered state and has no combinational path from tvalid.
- HI, on handshake:
  - store tdata in hi_reg and go to LO;
  - tlast=1 here is a framing error: err +1, go to DONE, no word emitted.
- LO, on handshake:
  - word_data <= {hi_reg, tdata}; word_valid <= 1;
  - word_count +1; on data mismatch with exp_word, err +1;
  - exp_word +1, mod 2^(2*IN_W).
- LO length and tlast check, with last = (word_count+1 == exp_len):
  - last & tlast: go to DONE.
  - last & ~tlast: err +1, go to DONE.
  - ~last & tlast: err +1 (early end), go to DONE.
  - otherwise: go to HI.
- One beat can produce both a mismatch and a framing error. In that case err adds 2, saturating.
- DONE: done=1 for one cycle, then go to IDLE. word_count and err_count hold until the next start.
- start outside IDLE is ignored. Beats presented in IDLE or DONE are not accepted (tready=0).
- word_count is LEN_W bits; with cnt_limit ≤ 2^LEN_W−1 it never wraps.

## Timing
- Reset values: state=IDLE, s_axis_tready=0, word_valid=0, word_data=0, word_count=0, err_count=0, busy=0, done=0, hi_reg=0, exp_word=0, exp_len=0.
- Reset asserted mid-frame: everything returns to the reset values immediately (asynchronous). A partial word is discarded and there is no done pulse.
- start at edge N: busy and tready are high from N+1.
- word_valid, word_data and the count updates are registered, one cycle after the LO handshake edge.
- done rises one cycle after the final handshake, together with the final word_valid. It lasts exactly one cycle.
- busy drops in the same cycle that done rises.
- Beats may arrive back-to-back: sustained throughput is one beat per cycle, one word per two cycles.
- hold or tvalid gaps may stall in either HI or LO indefinitely. hi_reg is retained across a stall.

## Test plan
- Reset, then seed=12, cnt_limit=10. Drive 20 back-to-back beats of the MSB-first halves of 12..21, with tlast on beat 20.
  - Required: 10 word_valid strobes with data 12..21;
  - word_count=10, err_count=0;
  - done one cycle after the 20th handshake.
- Same frame with tvalid toggling every cycle and hold high for 5 cycles mid-word. Required: identical words and counts; no beat accepted while hold=1.
- seed=63, cnt_limit=3. Required: words 63, 0, 1 (wrap) and err_count=0.
- cnt_limit=4, third word corrupted to 0x00 and tlast omitted on beat 8. Required: err_count=2, done after beat 8.
- cnt_limit=5, tlast on beat 3 (HI position). Required: err_count=1, word_count=1, done the next cycle, tready low afterwards.
- rst_n pulled low after beat 5 of a 10-word frame. Required: all outputs zero at once, no done. A following start runs a clean frame.
